// File: rtl/frame_blocker_pkg.sv
// Shared types and helpers for the frame_blocker raster-to-block reorder slice.

package frame_blocker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StEmit,
        StGap
    } fb_state_e;

    function automatic int unsigned calc_blocks_per_frame(input int unsigned frame_width,
                                                          input int unsigned frame_height,
                                                          input int unsigned block_size);
        return (frame_width / block_size) * (frame_height / block_size);
    endfunction

    // Counter width that never collapses to zero bits for single-valued ranges.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/band_buffer.sv
// Band storage: one write port, one read port with a registered read.

module band_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_blocker.sv
// Buffers one band of raster pixels, then replays it as BLOCK_SIZE x BLOCK_SIZE blocks
// in row-major order, left to right, with idle gaps between blocks.

module frame_blocker
    import frame_blocker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BLOCK_SIZE   = 8,
    parameter int unsigned FRAME_WIDTH  = 64,
    parameter int unsigned FRAME_HEIGHT = 64,
    parameter int unsigned BLOCK_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    input  logic                  pixel_sof,
    output logic                  pixel_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  start_data,
    output logic                  start_of_frame,
    output logic                  end_of_frame,
    output logic [31:0]           blocks_per_frame
);

    localparam int unsigned BlocksX = FRAME_WIDTH / BLOCK_SIZE;
    localparam int unsigned BandsY  = FRAME_HEIGHT / BLOCK_SIZE;
    localparam int unsigned Depth   = BLOCK_SIZE * FRAME_WIDTH;
    localparam int unsigned ColW    = cnt_width(FRAME_WIDTH);
    localparam int unsigned LineW   = cnt_width(BLOCK_SIZE);
    localparam int unsigned BandW   = cnt_width(BandsY);
    localparam int unsigned BlkW    = cnt_width(BlocksX);
    localparam int unsigned RowW    = $clog2(BLOCK_SIZE);
    localparam int unsigned SampW   = 2 * RowW;
    localparam int unsigned GapW    = cnt_width(BLOCK_GAP);
    localparam int unsigned AddrW   = cnt_width(Depth);

    localparam logic [ColW-1:0]  ColMax  = ColW'(FRAME_WIDTH - 1);
    localparam logic [LineW-1:0] LineMax = LineW'(BLOCK_SIZE - 1);
    localparam logic [BandW-1:0] BandMax = BandW'(BandsY - 1);
    localparam logic [BlkW-1:0]  BlkMax  = BlkW'(BlocksX - 1);
    localparam logic [SampW-1:0] SampMax = SampW'(BLOCK_SIZE * BLOCK_SIZE - 1);
    localparam logic [GapW-1:0]  GapMax  = GapW'(BLOCK_GAP - 1);

    fb_state_e        state_q, state_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [LineW-1:0] line_q, line_d;
    logic [BandW-1:0] band_q, band_d;
    logic [BlkW-1:0]  blk_q, blk_d;
    logic [SampW-1:0] samp_q, samp_d;
    logic [GapW-1:0]  gap_q, gap_d;

    logic             xfer, abort, restart, emit_fire;
    logic             wr_en, rd_en;
    logic [AddrW-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    logic pixel_ready_q;
    logic v1_q, sd1_q, sof1_q, eof1_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic data_valid_q, start_data_q, start_of_frame_q, end_of_frame_q;

    logic [RowW-1:0] rd_row, rd_col;

    assign rd_row  = samp_q[SampW-1:RowW];
    assign rd_col  = samp_q[RowW-1:0];
    assign rd_addr = AddrW'(rd_row) * AddrW'(FRAME_WIDTH)
                   + AddrW'(blk_q) * AddrW'(BLOCK_SIZE) + AddrW'(rd_col);

    always_comb begin
        xfer      = pixel_valid & pixel_ready_q;
        // A new frame start preempts emission, so sof is honoured even while ready is low.
        abort     = pixel_valid & pixel_sof & (state_q != StIdle);
        restart   = (xfer & pixel_sof) | abort;
        emit_fire = (state_q == StEmit) & ~abort;

        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        band_d  = band_q;
        blk_d   = blk_q;
        samp_d  = samp_q;
        gap_d   = gap_q;
        wr_en   = 1'b0;
        wr_addr = AddrW'(line_q) * AddrW'(FRAME_WIDTH) + AddrW'(col_q);
        rd_en   = 1'b0;

        if (restart) begin
            // The sof pixel lands at (0,0); counting resumes from column 1.
            wr_en   = 1'b1;
            wr_addr = '0;
            col_d   = ColW'(1);
            line_d  = '0;
            band_d  = '0;
            blk_d   = '0;
            samp_d  = '0;
            gap_d   = '0;
            state_d = StFill;
        end else begin
            case (state_q)
                StIdle: ;
                StFill: begin
                    if (xfer) begin
                        wr_en = 1'b1;
                        col_d = col_q + ColW'(1);
                        if (col_q == ColMax) begin
                            col_d = '0;
                            if (line_q == LineMax) begin
                                line_d  = '0;
                                blk_d   = '0;
                                samp_d  = '0;
                                state_d = StEmit;
                            end else begin
                                line_d = line_q + LineW'(1);
                            end
                        end
                    end
                end
                StEmit: begin
                    rd_en  = 1'b1;
                    samp_d = samp_q + SampW'(1);
                    if (samp_q == SampMax) begin
                        samp_d  = '0;
                        gap_d   = '0;
                        state_d = StGap;
                    end
                end
                StGap: begin
                    gap_d = gap_q + GapW'(1);
                    if (gap_q == GapMax) begin
                        gap_d = '0;
                        if (blk_q == BlkMax) begin
                            blk_d = '0;
                            if (band_q == BandMax) begin
                                band_d  = '0;
                                state_d = StIdle;
                            end else begin
                                band_d  = band_q + BandW'(1);
                                state_d = StFill;
                            end
                        end else begin
                            blk_d   = blk_q + BlkW'(1);
                            state_d = StEmit;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            line_q  <= '0;
            band_q  <= '0;
            blk_q   <= '0;
            samp_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            band_q  <= band_d;
            blk_q   <= blk_d;
            samp_q  <= samp_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_ready_q <= 1'b0;
        end else begin
            pixel_ready_q <= (state_d == StIdle) || (state_d == StFill);
        end
    end

    // Stage 1 runs alongside the RAM read; stage 2 is the output register.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            v1_q             <= 1'b0;
            sd1_q            <= 1'b0;
            sof1_q           <= 1'b0;
            eof1_q           <= 1'b0;
            data_out_q       <= '0;
            data_valid_q     <= 1'b0;
            start_data_q     <= 1'b0;
            start_of_frame_q <= 1'b0;
            end_of_frame_q   <= 1'b0;
        end else begin
            v1_q             <= emit_fire;
            sd1_q            <= emit_fire && (samp_q == '0);
            sof1_q           <= emit_fire && (samp_q == '0) && (blk_q == '0) && (band_q == '0);
            eof1_q           <= emit_fire && (blk_q == BlkMax) && (band_q == BandMax);
            data_out_q       <= v1_q ? rd_data : '0;
            data_valid_q     <= v1_q;
            start_data_q     <= sd1_q;
            start_of_frame_q <= sof1_q;
            end_of_frame_q   <= eof1_q;
        end
    end

    band_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (Depth),
        .ADDR_WIDTH (AddrW)
    ) u_band_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (pixel_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign pixel_ready      = pixel_ready_q;
    assign data_out         = data_out_q;
    assign data_valid       = data_valid_q;
    assign start_data       = start_data_q;
    assign start_of_frame   = start_of_frame_q;
    assign end_of_frame     = end_of_frame_q;
    assign blocks_per_frame = 32'(calc_blocks_per_frame(FRAME_WIDTH, FRAME_HEIGHT, BLOCK_SIZE));

endmodule

// File: tb/tb_frame_blocker.sv
// Directed bench for frame_blocker on an 8x8 frame split into 4x4 blocks.

module tb_frame_blocker;

    localparam int unsigned DW = 8;
    localparam int unsigned BS = 4;
    localparam int unsigned FW = 8;
    localparam int unsigned FH = 8;
    localparam int unsigned BG = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid;
    logic          pixel_sof;
    logic          pixel_ready;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          start_data;
    logic          start_of_frame;
    logic          end_of_frame;
    logic [31:0]   blocks_per_frame;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_blocker #(
        .DATA_WIDTH   (DW),
        .BLOCK_SIZE   (BS),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .BLOCK_GAP    (BG)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pixel_in         (pixel_in),
        .pixel_valid      (pixel_valid),
        .pixel_sof        (pixel_sof),
        .pixel_ready      (pixel_ready),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .start_data       (start_data),
        .start_of_frame   (start_of_frame),
        .end_of_frame     (end_of_frame),
        .blocks_per_frame (blocks_per_frame)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pixel at raster index idx (y*8+x) carries value base+idx.
    function automatic logic [31:0] exp_pix(input int base, input int band, input int blk,
                                            input int s);
        return 32'((base + band * 32 + (s / 4) * 8 + blk * 4 + (s % 4)) & 255);
    endfunction

    task automatic feed(input int first, input int last, input int base, input bit rnd);
        int  idx;
        int  budget;
        bit  xfer;
        idx    = first;
        budget = 0;
        while (idx <= last && budget < 2000) begin
            pixel_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pixel_in    = DW'(base + idx);
            pixel_sof   = (idx == 0);
            xfer        = pixel_valid && pixel_ready;
            step();
            if (xfer) idx++;
            budget++;
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        chk("feed_count", 32'(idx), 32'(last + 1));
    endtask

    task automatic check_block(input int band, input int blk, input int base, input int n);
        for (int s = 0; s < n; s++) begin
            chk("dv", 32'(data_valid), 32'd1);
            chk("data", 32'(data_out), exp_pix(base, band, blk, s));
            chk("start_data", 32'(start_data), 32'(s == 0));
            chk("sof", 32'(start_of_frame), 32'(band == 0 && blk == 0 && s == 0));
            chk("eof", 32'(end_of_frame), 32'(band == 1 && blk == 1));
            chk("ready_emit", 32'(pixel_ready), 32'd0);
            step();
        end
    endtask

    task automatic gap2(input bit intra);
        for (int g = 0; g < 2; g++) begin
            chk("gap_dv", 32'(data_valid), 32'd0);
            chk("gap_data", 32'(data_out), 32'd0);
            if (intra) chk("gap_ready", 32'(pixel_ready), 32'd0);
            step();
        end
    endtask

    // Entered right after the last band pixel was taken: two quiet cycles, then samples.
    task automatic emit_band(input int band, input int base);
        chk("lat0_dv", 32'(data_valid), 32'd0);
        step();
        chk("lat1_dv", 32'(data_valid), 32'd0);
        step();
        check_block(band, 0, base, 16);
        gap2(1'b1);
        check_block(band, 1, base, 16);
        gap2(1'b0);
    endtask

    task automatic do_frame(input int base, input bit rnd);
        feed(0, 31, base, rnd);
        emit_band(0, base);
        feed(32, 63, base, rnd);
        emit_band(1, base);
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        step();
        step();
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_sd", 32'(start_data), 32'd0);
        chk("rst_sof", 32'(start_of_frame), 32'd0);
        chk("rst_eof", 32'(end_of_frame), 32'd0);
        chk("rst_ready", 32'(pixel_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(pixel_ready), 32'd1);
        chk("bpf", blocks_per_frame, 32'd4);

        // Non-sof pixels before any frame start are swallowed.
        pixel_valid = 1'b1;
        pixel_sof   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pixel_in = DW'(200 + i);
            step();
            chk("presof_dv", 32'(data_valid), 32'd0);
            chk("presof_ready", 32'(pixel_ready), 32'd1);
        end
        pixel_valid = 1'b0;
        step();
        step();
        chk("presof_idle_dv", 32'(data_valid), 32'd0);

        // Ramp frame, continuous input.
        do_frame(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("post_frame_dv", 32'(data_valid), 32'd0);
            chk("post_frame_ready", 32'(pixel_ready), 32'd1);
            step();
        end

        // Same ramp with bursty input must emit identically.
        do_frame(0, 1'b1);

        // Abort during block 1 of band 0.
        feed(0, 31, 10, 1'b0);
        chk("ab_lat0_dv", 32'(data_valid), 32'd0);
        step();
        step();
        check_block(0, 0, 10, 16);
        gap2(1'b1);
        check_block(0, 1, 10, 3);
        pixel_valid = 1'b1;
        pixel_sof   = 1'b1;
        pixel_in    = DW'(128);
        step();
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        chk("abort_dv", 32'(data_valid), 32'd0);
        chk("abort_data", 32'(data_out), 32'd0);
        chk("abort_sd", 32'(start_data), 32'd0);
        chk("abort_ready", 32'(pixel_ready), 32'd1);
        feed(1, 31, 128, 1'b0);
        emit_band(0, 128);
        feed(32, 63, 128, 1'b0);
        emit_band(1, 128);

        // Reset pulse during band 1 fill discards the frame.
        feed(0, 31, 30, 1'b0);
        emit_band(0, 30);
        feed(32, 40, 30, 1'b0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_dv", 32'(data_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_ready", 32'(pixel_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready_rel", 32'(pixel_ready), 32'd1);
        chk("mid_rst_dv_rel", 32'(data_valid), 32'd0);
        do_frame(50, 1'b1);
        chk("final_dv", 32'(data_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
